simple_design_exerciser: RTL

//  Self-checking driver/monitor for the 3-input/4-output combinational simple_design.

---
 rtl/simple_design_pkg.sv | 25 ++
 rtl/simple_design_exerciser.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/simple_design_pkg.sv
// Shared widths, golden table and FSM encoding for the simple_design exerciser.
package simple_design_pkg;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned OBS_W   = 4;
    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned FAIL_W  = 4;
    localparam int unsigned TBL_W   = NUM_VEC * OBS_W;

    localparam logic [TBL_W-1:0] EXPECTED_DEFAULT = 32'hF1A3_A821;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } exer_state_t;

    // Nibble v of the table is the expected {oa,ob,oc,od} for stimulus v = {i1,i2,i3}.
    function automatic logic [OBS_W-1:0] expected_obs(input logic [TBL_W-1:0] tbl,
                                                      input logic [VEC_W-1:0] v);
        return tbl[OBS_W*32'(v) +: OBS_W];
    endfunction

endpackage

// File: rtl/simple_design_exerciser.sv
// Sweeps all eight {i1,i2,i3} vectors into simple_design, holds each for SETTLE_CYCLES,
// samples {oa,ob,oc,od} for one cycle and accumulates pass/fail results.
module simple_design_exerciser
    import simple_design_pkg::*;
#(
    parameter int unsigned       SETTLE_CYCLES = 2,
    parameter logic [TBL_W-1:0]  EXPECTED      = EXPECTED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              oa,
    input  logic              ob,
    input  logic              oc,
    input  logic              od,
    output logic              i1,
    output logic              i2,
    output logic              i3,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FAIL_W-1:0] fail_count,
    output logic [VEC_W-1:0]  first_fail_vec,
    output logic [OBS_W-1:0]  first_fail_obs
);

    localparam int unsigned      CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

    exer_state_t       state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [VEC_W-1:0]  ffv_q, ffv_d;
    logic [OBS_W-1:0]  ffo_q, ffo_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [OBS_W-1:0]  obs_c;
    logic [OBS_W-1:0]  exp_c;
    logic              mismatch_c;
    logic              settle_done_c;
    logic              last_vec_c;
    logic              accept_c;

    assign obs_c         = {oa, ob, oc, od};
    assign exp_c         = expected_obs(EXPECTED, vec_q);
    assign mismatch_c    = (obs_c != exp_c);
    assign settle_done_c = (cnt_q == SETTLE_LAST);
    assign last_vec_c    = (vec_q == VEC_LAST);
    assign accept_c      = start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start)         state_d = SETTLE;
            SETTLE:     if (settle_done_c) state_d = SAMPLE;
            SAMPLE:     state_d = last_vec_c ? DONE : SETTLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath/output next values; the stimulus outputs are vec_q itself.
    always_comb begin
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        fail_d = fail_q;
        ffv_d  = ffv_q;
        ffo_d  = ffo_q;
        pass_d = pass_q;
        done_d = done_q;
        busy_d = busy_q;

        if (accept_c) begin
            vec_d  = '0;
            cnt_d  = '0;
            fail_d = '0;
            ffv_d  = '0;
            ffo_d  = '0;
            pass_d = 1'b0;
            done_d = 1'b0;
            busy_d = 1'b1;
        end else if (state_q == SETTLE) begin
            cnt_d = settle_done_c ? '0 : cnt_q + CNT_W'(1);
        end else if (state_q == SAMPLE) begin
            if (mismatch_c) begin
                fail_d = fail_q + FAIL_W'(1);
                if (fail_q == '0) begin
                    ffv_d = vec_q;
                    ffo_d = obs_c;
                end
            end
            if (last_vec_c) begin
                done_d = 1'b1;
                busy_d = 1'b0;
                pass_d = (fail_d == '0);
            end else begin
                vec_d = vec_q + VEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            fail_q <= '0;
            ffv_q  <= '0;
            ffo_q  <= '0;
            pass_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            fail_q <= fail_d;
            ffv_q  <= ffv_d;
            ffo_q  <= ffo_d;
            pass_q <= pass_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign {i1, i2, i3}   = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_obs = ffo_q;

endmodule
